store_control: RTL and testbench
================================

// Module: store_control
// PURPOSE
//  Consumer side of the store instruction FIFO and the activation out FIFO, both written by activation control.
//  Decodes STORE instructions and drains the activation results to DRAM as one AXI4 INCR write burst each.
//  Consumes FENCE instructions and signals completion. Unknown opcodes are dropped and flagged.
//  Last stage of the load/execute/activation/store instruction pipeline.
// PARAMETERS
//  AXI_WIDTH_ID   4                 AXI ID width; awid driven 0
//  AXI_WIDTH_AD   32                AXI address width
//  AXI_WIDTH_DA   32                AXI data width = activation out FIFO width
//  AXI_WIDTH_DS   AXI_WIDTH_DA/8    strobe width
//  DRAM_BASE_ADDR 32'h1000_0000     byte base added to the instruction address
// PORTS
//  clk                              in   1     clock; all logic on posedge
//  rst                              in   1     synchronous reset, active-high
//  i_store_instruction_fifo_empty   in   1     instruction FIFO empty
//  i_store_instruction_data         in   32    instruction at FIFO head (FWFT)
//  o_store_instruction_fifo_rd_en   out  1     instruction pop
//  i_activation_out_fifo_empty      in   1     result FIFO empty
//  i_activation_out_fifo_data       in   DA    result data; valid 1 cycle after rd_en
//  o_activation_out_fifo_rd_en      out  1     result pop
//  o_awid/o_awaddr/o_awlen          out  ID/AD/8   AW payload
//  o_awsize/o_awburst               out  3/2   log2(DS) / 2'b01 (INCR)
//  o_awvalid, i_awready             out/in 1   AW handshake
//  o_wdata/o_wstrb/o_wlast          out  DA/DS/1   W payload; wstrb all ones
//  o_wvalid, i_wready               out/in 1   W handshake
//  i_bid/i_bresp                    in   ID/2  B response
//  i_bvalid, o_bready               in/out 1   B handshake
//  o_store_idle                     out  1     state==IDLE
//  o_store_done                     out  1     1-cycle pulse per FENCE
//  o_resp_error                     out  1     sticky: bresp!=OKAY seen
//  o_instr_error                    out  1     sticky: unknown opcode seen
// BEHAVIOUR
//  Instruction format: [31:29] opcode, [28:11] beat address A, [10:3] beat count-1 L, [2:0] reserved.
//  Opcodes: STORE=3'b100, FENCE=3'b111; all others illegal.
//  Reset values: all outputs 0 except o_store_idle=1, o_awsize=log2(DS), o_awburst=2'b01.
//    Counters clear. Sticky flags clear only on rst.
//  FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE (one-hot).
//  IDLE: when FIFO is not empty, assert rd_en combinationally in the same cycle.
//    STORE: latch awaddr = DRAM_BASE_ADDR + (A << log2(DS)) and awlen = L; go to ADDR.
//    FENCE: o_store_done pulses the next cycle; stay in IDLE.
//    Illegal: set o_instr_error; stay in IDLE.
//  ADDR: o_awvalid=1 with a stable payload until awvalid&awready, then go to DATA.
//  DATA: pop the result FIFO only when all of these hold: FIFO not empty, skid occupancy + in-flight pop < 2, pops issued < L+1.
//    Exactly L+1 pops per burst. o_wvalid = skid not empty.
//    o_wlast=1 on the beat where beat_cnt==L; L=0 gives a single beat with wlast.
//    On the wvalid&wready&wlast handshake, go to RESP.
//  RESP: o_bready=1. On bvalid, set o_resp_error if bresp!=2'b00, then go to IDLE.
//  Throughput: 1 beat/cycle with wready held high and the FIFO non-empty; no bubbles from the skid buffer.
//  Result FIFO empty mid-burst: wvalid drops, payload held, no timeout. wready low: hold wdata/wlast stable.
//  awready asserted before awvalid: legal, no effect.
//  Only one burst outstanding; the next instruction is not popped until the B response arrives.
//  4KB crossing is not checked; the compiler guarantees bursts stay within 4KB.
//  Reset mid-burst: immediate return to reset values. The AXI slave must share the reset.
// STRUCTURE
//  Shared package bna_isa_pkg holds:
//    opcode constants (ACT=3'b011, STORE, FENCE) and instruction field LSB/MSB positions;
//    AXI_BURST_INCR and AXI_RESP_OKAY.
//  Sub-module store_wdata_skid: 2-entry FIFO with registered outputs.
//    Takes the delayed FIFO read strobe as the write and W handshake as the read.
//    Exports its count for pop gating.
// TESTING
//  1. STORE A=0x10, L=3, FIFO holds D0..D3, ready tied high:
//     awaddr=0x1000_0040, awlen=3; 4 beats D0..D3 on consecutive cycles; wlast on D3 only; idle after B.
//  2. L=0: single beat with wlast=1; exactly one FIFO pop.
//  3. wready toggled randomly and FIFO empty for 5 cycles mid-burst:
//     data in order, no loss or duplication, payload stable while wvalid & !wready.
//  4. Mixed stream STORE, FENCE, opcode 3'b010:
//     done pulses once after the STORE's B response; instr_error set; illegal word popped.
//  5. bresp=SLVERR: resp_error sets and stays set through a later OKAY burst.
//  6. rst asserted mid-DATA: next cycle all valids 0, idle=1; a new STORE after reset completes normally.

Source files
------------

// File: rtl/bna_isa_pkg.sv
// Shared ISA definitions for the load/execute/activation/store pipeline:
// opcodes, instruction field positions, AXI constants and the store FSM encoding.
package bna_isa_pkg;

  localparam logic [2:0] OP_ACT   = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_FENCE = 3'b111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int ADDR_MSB   = 28;
  localparam int ADDR_LSB   = 11;
  localparam int LEN_MSB    = 10;
  localparam int LEN_LSB    = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_DATA = 4'b0100,
    S_RESP = 4'b1000
  } store_state_t;

endpackage

// File: rtl/store_wdata_skid.sv
// Two-entry FIFO with registered head; buffers result-FIFO read latency so the
// W channel can stream one beat per cycle. Count is exported for pop gating.
module store_wdata_skid #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail_q;
  logic             do_rd;
  logic             do_wr;

  assign do_rd = rd_en && (count != 2'd0);
  assign do_wr = wr_en && ((count != 2'd2) || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      tail_q  <= '0;
      count   <= 2'd0;
    end else begin
      case ({do_wr, do_rd})
        2'b10: begin
          if (count == 2'd0) rd_data <= wr_data;
          else               tail_q  <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) rd_data <= tail_q;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            rd_data <= wr_data;
          end else begin
            rd_data <= tail_q;
            tail_q  <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/store_control.sv
// Store stage: pops STORE/FENCE instructions and drains activation results to
// DRAM as a single AXI4 INCR write burst per STORE, one burst outstanding.
module store_control
  import bna_isa_pkg::*;
#(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
  parameter logic [AXI_WIDTH_AD-1:0] DRAM_BASE_ADDR = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_store_instruction_fifo_empty,
  input  logic [31:0]             i_store_instruction_data,
  output logic                    o_store_instruction_fifo_rd_en,
  input  logic                    i_activation_out_fifo_empty,
  input  logic [AXI_WIDTH_DA-1:0] i_activation_out_fifo_data,
  output logic                    o_activation_out_fifo_rd_en,
  output logic [AXI_WIDTH_ID-1:0] o_awid,
  output logic [AXI_WIDTH_AD-1:0] o_awaddr,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [AXI_WIDTH_DA-1:0] o_wdata,
  output logic [AXI_WIDTH_DS-1:0] o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [AXI_WIDTH_ID-1:0] i_bid,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic                    o_store_idle,
  output logic                    o_store_done,
  output logic                    o_resp_error,
  output logic                    o_instr_error
);

  localparam int SIZE_LOG2 = $clog2(AXI_WIDTH_DS);

  store_state_t state, state_next;

  logic [2:0]  opcode;
  logic [17:0] beat_addr;
  logic [7:0]  beat_len;
  logic        instr_avail;
  logic        w_hs;
  logic        pop_en;
  logic        pop_inflight;
  logic [8:0]  pop_cnt;
  logic [8:0]  burst_beats;
  logic [7:0]  wr_beat;
  logic [1:0]  skid_count;
  logic [2:0]  occupancy;
  logic        unused_inputs;

  assign opcode      = i_store_instruction_data[OPCODE_MSB:OPCODE_LSB];
  assign beat_addr   = i_store_instruction_data[ADDR_MSB:ADDR_LSB];
  assign beat_len    = i_store_instruction_data[LEN_MSB:LEN_LSB];
  assign instr_avail = !i_store_instruction_fifo_empty;
  assign w_hs        = o_wvalid && i_wready;
  assign burst_beats = {1'b0, o_awlen} + 9'd1;

  // Occupancy after this cycle's W handshake, so a draining skid keeps the pop stream gap-free.
  assign occupancy = {1'b0, skid_count} + {2'b00, pop_inflight} - {2'b00, w_hs};

  assign o_awid      = '0;
  assign o_awsize    = 3'(SIZE_LOG2);
  assign o_awburst   = AXI_BURST_INCR;
  assign o_wvalid    = (skid_count != 2'd0);
  assign o_wstrb     = {AXI_WIDTH_DS{o_wvalid}};
  assign o_activation_out_fifo_rd_en = pop_en;
  assign unused_inputs = ^{i_bid, i_store_instruction_data[2:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_avail && opcode == OP_STORE) state_next = S_ADDR;
      S_ADDR:  if (i_awready) state_next = S_DATA;
      S_DATA:  if (w_hs && o_wlast) state_next = S_RESP;
      S_RESP:  if (i_bvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_store_instruction_fifo_rd_en = 1'b0;
    o_awvalid    = 1'b0;
    o_bready     = 1'b0;
    o_store_idle = 1'b0;
    pop_en       = 1'b0;
    case (state)
      S_IDLE: begin
        o_store_idle = 1'b1;
        o_store_instruction_fifo_rd_en = instr_avail;
      end
      S_ADDR: o_awvalid = 1'b1;
      S_DATA: pop_en = !i_activation_out_fifo_empty && (occupancy < 3'd2) && (pop_cnt < burst_beats);
      S_RESP: o_bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_awaddr      <= '0;
      o_awlen       <= '0;
      pop_cnt       <= '0;
      wr_beat       <= '0;
      pop_inflight  <= 1'b0;
      o_store_done  <= 1'b0;
      o_resp_error  <= 1'b0;
      o_instr_error <= 1'b0;
    end else begin
      pop_inflight <= pop_en;
      o_store_done <= 1'b0;
      if (state == S_IDLE && instr_avail) begin
        case (opcode)
          OP_STORE: begin
            o_awaddr <= DRAM_BASE_ADDR + (AXI_WIDTH_AD'(beat_addr) << SIZE_LOG2);
            o_awlen  <= beat_len;
            pop_cnt  <= '0;
            wr_beat  <= '0;
          end
          OP_FENCE: o_store_done  <= 1'b1;
          default:  o_instr_error <= 1'b1;
        endcase
      end
      if (pop_en)       pop_cnt <= pop_cnt + 9'd1;
      if (pop_inflight) wr_beat <= wr_beat + 8'd1;
      if (state == S_RESP && i_bvalid && i_bresp != AXI_RESP_OKAY) o_resp_error <= 1'b1;
    end
  end

  // The last flag travels with its data word so wlast is registered alongside wdata.
  store_wdata_skid #(
    .WIDTH(AXI_WIDTH_DA + 1)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pop_inflight),
    .wr_data ({(wr_beat == o_awlen), i_activation_out_fifo_data}),
    .rd_en   (w_hs),
    .rd_data ({o_wlast, o_wdata}),
    .count   (skid_count)
  );

endmodule

// File: tb/tb_store_control.sv
// Scoreboard bench for store_control: FIFO and AXI slave models, a reference
// model that predicts bursts/flags from instructions, and an independent monitor.
module tb_store_control;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [2:0]  OP_STORE = 3'b100;
  localparam logic [2:0]  OP_FENCE = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_empty = 1'b1;
  logic [31:0] instr_data = '0;
  logic        instr_rd_en;
  logic        act_empty = 1'b1;
  logic [31:0] act_data = '0;
  logic        act_rd_en;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [3:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        store_idle;
  logic        store_done;
  logic        resp_error;
  logic        instr_error;

  always #5 clk = ~clk;

  store_control dut (
    .clk                            (clk),
    .rst                            (rst),
    .i_store_instruction_fifo_empty (instr_empty),
    .i_store_instruction_data       (instr_data),
    .o_store_instruction_fifo_rd_en (instr_rd_en),
    .i_activation_out_fifo_empty    (act_empty),
    .i_activation_out_fifo_data     (act_data),
    .o_activation_out_fifo_rd_en    (act_rd_en),
    .o_awid                         (awid),
    .o_awaddr                       (awaddr),
    .o_awlen                        (awlen),
    .o_awsize                       (awsize),
    .o_awburst                      (awburst),
    .o_awvalid                      (awvalid),
    .i_awready                      (awready),
    .o_wdata                        (wdata),
    .o_wstrb                        (wstrb),
    .o_wlast                        (wlast),
    .o_wvalid                       (wvalid),
    .i_wready                       (wready),
    .i_bid                          (bid),
    .i_bresp                        (bresp),
    .i_bvalid                       (bvalid),
    .o_bready                       (bready),
    .o_store_idle                   (store_idle),
    .o_store_done                   (store_done),
    .o_resp_error                   (resp_error),
    .o_instr_error                  (instr_error)
  );

  logic [31:0] instr_q[$];
  logic [31:0] act_q[$];
  logic [1:0]  bresp_q[$];
  logic [39:0] exp_aw[$];
  logic [32:0] exp_w[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int exp_pops = 0, act_pop_cnt = 0;
  int exp_done = 0, done_seen = 0;
  bit exp_resp_err = 0, exp_instr_err = 0;
  bit ready_random = 0;
  int stall_at_beat = -1, stall = 0;
  int w_beats = 0, cyc = 0, first_cyc = 0, last_span = -1;
  int last_b_cyc = 0, last_done_cyc = 0;
  bit burst_first = 0, held = 0;
  logic [32:0] held_val = '0;
  bit s_instr_pop, s_act_pop, s_wlast_hs, s_b_hs, b_pending = 0;
  int b_wait = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: a STORE becomes one burst at BASE + 4*A of the next L+1 result words.
  task automatic applyStimulus(input logic [2:0] op, input logic [17:0] a, input logic [7:0] l,
                               input logic [1:0] resp);
    logic [31:0] d;
    instr_q.push_back({op, a, l, 3'($urandom)});
    if (op == OP_STORE) begin
      exp_aw.push_back({BASE + 32'(a) * 32'd4, l});
      for (int i = 0; i <= int'(l); i++) begin
        d = $urandom;
        act_q.push_back(d);
        exp_w.push_back({(i == int'(l)), d});
      end
      bresp_q.push_back(resp);
      exp_pops += int'(l) + 1;
      if (resp != 2'b00) exp_resp_err = 1;
    end else if (op == OP_FENCE) begin
      exp_done++;
    end else begin
      exp_instr_err = 1;
    end
  endtask

  task automatic drainAndCheck(input string tag);
    int n = 0;
    bit timed_out;
    while (!(instr_q.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0 &&
             bresp_q.size() == 0 && !bvalid && store_idle === 1'b1) && n < 3000) begin
      @(posedge clk); #3;
      n++;
    end
    timed_out = (n >= 3000);
    repeat (3) begin @(posedge clk); #3; end
    checkOutput({tag, "_timeout"},   timed_out, 0);
    checkOutput({tag, "_idle"},      store_idle, 1);
    checkOutput({tag, "_w_left"},    exp_w.size(), 0);
    checkOutput({tag, "_pops"},      act_pop_cnt, exp_pops);
    checkOutput({tag, "_done"},      done_seen, exp_done);
    checkOutput({tag, "_instr_err"}, instr_error, exp_instr_err);
    checkOutput({tag, "_resp_err"},  resp_error, exp_resp_err);
  endtask

  // FIFO and AXI slave models: sample handshakes mid-cycle, update just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      s_instr_pop = instr_rd_en && !instr_empty;
      s_act_pop   = act_rd_en;
      s_wlast_hs  = wvalid && wready && wlast;
      s_b_hs      = bvalid && bready;
      @(posedge clk); #1;
      if (rst) begin
        instr_empty = 1'b1;
        act_empty   = 1'b1;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        b_pending   = 0;
        stall       = 0;
      end else begin
        if (s_instr_pop && instr_q.size() > 0) void'(instr_q.pop_front());
        if (s_act_pop) begin
          act_pop_cnt++;
          if (act_q.size() > 0) act_data = act_q.pop_front();
        end
        if (s_b_hs) bvalid = 1'b0;
        if (s_wlast_hs) begin
          b_pending = 1;
          b_wait    = $urandom_range(0, 3);
        end
        if (b_pending && !bvalid) begin
          if (b_wait == 0) begin
            bvalid    = 1'b1;
            bresp     = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
            b_pending = 0;
          end else begin
            b_wait--;
          end
        end
        if (stall_at_beat >= 0 && w_beats >= stall_at_beat) begin
          stall = 5;
          stall_at_beat = -1;
        end
        instr_empty = (instr_q.size() == 0);
        instr_data  = (instr_q.size() > 0) ? instr_q[0] : 32'h0;
        act_empty   = (act_q.size() == 0) || (stall > 0);
        if (stall > 0) stall--;
        awready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes an AW or W transfer.
  always @(negedge clk) begin
    logic [39:0] ea;
    logic [32:0] ew;
    cyc++;
    if (rst) begin
      held = 0;
    end else begin
      if (store_done) begin
        done_seen++;
        last_done_cyc = cyc;
      end
      if (bvalid && bready) last_b_cyc = cyc;
      if (awvalid && awready) begin
        checkOutput("aw_expected_pending", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          ea = exp_aw.pop_front();
          checkOutput("awaddr", awaddr, ea[39:8]);
          checkOutput("awlen", awlen, ea[7:0]);
        end
        burst_first = 1;
      end
      if (held) begin
        checkOutput("w_hold_valid", wvalid, 1);
        checkOutput("w_hold_payload", {wlast, wdata}, held_val);
        held = 0;
      end
      if (wvalid && wready) begin
        checkOutput("w_expected_pending", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          ew = exp_w.pop_front();
          checkOutput("wdata", wdata, ew[31:0]);
          checkOutput("wlast", wlast, ew[32]);
        end
        if (burst_first) begin
          first_cyc   = cyc;
          burst_first = 0;
        end
        if (wlast) last_span = cyc - first_cyc;
        w_beats++;
      end else if (wvalid) begin
        held     = 1;
        held_val = {wlast, wdata};
      end
    end
  end

  initial begin
    int n;
    int start;
    logic [2:0] op;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idle", store_idle, 1);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_wlast", wlast, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_done", store_done, 0);
    checkOutput("rst_errors", {resp_error, instr_error}, 0);
    checkOutput("rst_awsize", awsize, 3'd2);
    checkOutput("rst_awburst", awburst, 2'b01);
    checkOutput("rst_awaddr", awaddr, 0);
    @(posedge clk); #3;
    rst = 1'b0;

    ready_random = 0;
    applyStimulus(OP_STORE, 18'h10, 8'd3, 2'b00);
    drainAndCheck("t1");
    checkOutput("t1_beat_span", last_span, 3);

    applyStimulus(OP_STORE, 18'h3_ffff, 8'd0, 2'b00);
    drainAndCheck("t2");
    checkOutput("t2_beat_span", last_span, 0);

    ready_random  = 1;
    stall_at_beat = w_beats + 2;
    applyStimulus(OP_STORE, 18'h0_0123, 8'd11, 2'b00);
    drainAndCheck("t3");

    ready_random = 0;
    applyStimulus(OP_STORE, 18'h0_0200, 8'd2, 2'b00);
    applyStimulus(OP_FENCE, 18'h0, 8'd0, 2'b00);
    applyStimulus(3'b010, 18'h0_0abc, 8'd5, 2'b00);
    drainAndCheck("t4");
    checkOutput("t4_done_after_b", last_done_cyc > last_b_cyc, 1);

    applyStimulus(OP_STORE, 18'h0_0300, 8'd1, 2'b10);
    drainAndCheck("t5a");
    applyStimulus(OP_STORE, 18'h0_0400, 8'd4, 2'b00);
    drainAndCheck("t5b");

    ready_random = 1;
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 9);
      if (n <= 6) begin
        applyStimulus(OP_STORE, 18'($urandom), 8'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
      end else if (n == 7) begin
        applyStimulus(OP_FENCE, 18'h0, 8'd0, 2'b00);
      end else begin
        op = 3'($urandom_range(0, 7));
        if (op == OP_STORE || op == OP_FENCE) op = 3'b001;
        applyStimulus(op, 18'($urandom), 8'($urandom), 2'b00);
      end
    end
    drainAndCheck("rand");

    ready_random = 0;
    applyStimulus(OP_STORE, 18'h0_0055, 8'd15, 2'b00);
    start = w_beats;
    n = 0;
    while (w_beats < start + 2 && n < 500) begin
      @(posedge clk); #3;
      n++;
    end
    checkOutput("t6_reached_data", w_beats >= start + 2, 1);
    rst = 1'b1;
    instr_q.delete();
    act_q.delete();
    bresp_q.delete();
    exp_aw.delete();
    exp_w.delete();
    exp_pops = 0; act_pop_cnt = 0;
    exp_done = 0; done_seen = 0;
    exp_resp_err = 0; exp_instr_err = 0;
    stall_at_beat = -1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_awvalid", awvalid, 0);
    checkOutput("t6_wvalid", wvalid, 0);
    checkOutput("t6_bready", bready, 0);
    checkOutput("t6_idle", store_idle, 1);
    checkOutput("t6_flags", {resp_error, instr_error, store_done}, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    applyStimulus(OP_STORE, 18'h0_0077, 8'd5, 2'b00);
    drainAndCheck("t6");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", checks_passed, checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
